// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared types, constants and byte-level helpers for AES rounds
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLK_W = 128;

    // Legal round counts for AES-128 / AES-192 / AES-256
    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Byte (row r, column c) lives at [127-8*(4c+r) -: 8]; row r rotates left by r.
    function automatic logic [AES_BLK_W-1:0] shift_rows(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return t;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_enc_seq_mixcolumns.sv
`default_nettype none
// ============================================================================
// Module      : mixcolumns
// Description : Combinational AES MixColumns over a 128-bit column-major state
// Revision    : 1.0 - initial release
// ============================================================================
module mixcolumns
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] i_data,
    output logic [AES_BLK_W-1:0] o_data
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0;
        logic [7:0] w_a1;
        logic [7:0] w_a2;
        logic [7:0] w_a3;

        assign w_a0 = i_data[127-32*c -: 8];
        assign w_a1 = i_data[119-32*c -: 8];
        assign w_a2 = i_data[111-32*c -: 8];
        assign w_a3 = i_data[103-32*c -: 8];

        // 3*x is xtime(x) ^ x
        assign o_data[127-32*c -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign o_data[119-32*c -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        assign o_data[111-32*c -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        assign o_data[103-32*c -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end

endmodule
`default_nettype wire

// File: rtl/aes_enc_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_enc_seq
// Description : Iterative one-round-per-cycle AES encryptor; S-box and key
//               schedule are supplied by the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_enc_seq
    import aes_pkg::*;
#(
    parameter int NR = 10
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic [3:0]           rk_idx,
    input  logic [AES_BLK_W-1:0] rk_data,
    output logic [AES_BLK_W-1:0] sb_in,
    input  logic [AES_BLK_W-1:0] sb_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 busy
);

    localparam logic [3:0] C_NR_LAST = 4'(NR);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_round;
    logic [3:0]           w_round_nxt;
    logic [AES_BLK_W-1:0] r_blk;
    logic [AES_BLK_W-1:0] w_blk_nxt;
    logic [AES_BLK_W-1:0] w_sr;
    logic [AES_BLK_W-1:0] w_mc;

    assign w_sr = shift_rows(sb_out);

    mixcolumns u_mixcolumns (
        .i_data (w_sr),
        .o_data (w_mc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_round <= 4'd0;
            r_blk   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_blk   <= w_blk_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_blk_nxt   = r_blk;
        in_ready    = 1'b0;
        rk_idx      = 4'd0;

        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_ROUND: begin
                rk_idx = r_round;
                if (r_round == C_NR_LAST) begin
                    w_blk_nxt   = w_sr ^ rk_data;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_blk_nxt   = w_mc ^ rk_data;
                    w_round_nxt = r_round + 4'd1;
                end
            end
            ST_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_round_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Accept overrides the above, so a DONE hand-off starts the next block without a bubble
        if (in_valid && in_ready) begin
            w_blk_nxt   = in_data ^ rk_data;
            w_round_nxt = 4'd1;
            w_state_nxt = ST_ROUND;
        end
    end

    assign sb_in     = r_blk;
    assign out_data  = r_blk;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_enc_seq
// Description : Directed self-checking bench for aes_enc_seq (FIPS-197 vectors)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_enc_seq;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic [127:0] sb_in;
    logic [127:0] sb_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [127:0] rks [2][11];
    logic         keysel = 1'b0;

    always #5 clk = ~clk;

    aes_enc_seq #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .sb_in     (sb_in),
        .sb_out    (sb_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX_TBL;
        return t[2047-8*int'(x) -: 8];
    endfunction

    always_comb begin
        sb_out = '0;
        for (int b = 0; b < 16; b++) begin
            sb_out[127-8*b -: 8] = sbox_lookup(sb_in[127-8*b -: 8]);
        end
    end

    assign rk_data = (rk_idx <= 4'd10) ? rks[keysel][rk_idx] : '0;

    task automatic expand_key(input logic [127:0] key, input int slot);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_lookup(t[31:24]), sbox_lookup(t[23:16]),
                     sbox_lookup(t[15:8]), sbox_lookup(t[7:0])} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rks[slot][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one block from IDLE/DONE; in_valid is kept high for 'pulse' ROUND cycles with junk data.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] exp,
                             input logic ksel, input int pulse);
        int n;
        keysel   = ksel;
        in_data  = pt;
        in_valid = 1'b1;
        tick();
        check({tag, "_r1"}, {123'd0, busy, rk_idx}, {123'd0, 1'b1, 4'd1});
        in_data  = ~pt;
        in_valid = (pulse > 0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
            if (n >= pulse) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check({tag, "_lat"}, 128'(n + 1), 128'd11);
        check({tag, "_ct"}, out_data, exp);
    endtask

    initial begin
        int n;
        int seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        expand_key(KEY_B, 0);
        expand_key(KEY_C, 1);
        tick();
        tick();
        rst = 1'b0;
        check("rst_flags", {125'd0, out_valid, busy, in_ready}, {125'd0, 3'b001});
        check("rst_data", out_data, '0);
        check("rst_sbin", sb_in, '0);
        check("rst_rkidx", 128'(rk_idx), 128'd0);

        // Single blocks
        run_block("appB", PT_B, CT_B, 1'b0, 0);
        tick();
        check("appB_idle", {126'd0, busy, out_valid}, '0);
        run_block("appC", PT_C, CT_C, 1'b1, 0);
        tick();

        // Backpressure: result must hold while out_ready is low, even with a new block offered
        out_ready = 1'b0;
        run_block("bp", PT_B, CT_B, 1'b0, 0);
        in_valid = 1'b1;
        in_data  = PT_C;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_data", out_data, CT_B);
            check("bp_flags", {125'd0, out_valid, in_ready, busy}, {125'd0, 3'b101});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", {126'd0, busy, out_valid}, '0);

        // in_valid pulsed during ROUND must be ignored
        run_block("pulse", PT_B, CT_B, 1'b0, 4);
        tick();

        // Back-to-back: second accept on the first block's DONE cycle
        keysel   = 1'b0;
        in_data  = PT_B;
        in_valid = 1'b1;
        tick();
        in_data = PT_C;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("b2b_lat1", 128'(n + 1), 128'd11);
        check("b2b_ct1", out_data, CT_B);
        check("b2b_rdy", 128'(in_ready), 128'd1);
        keysel = 1'b1;
        tick();
        in_valid = 1'b0;
        check("b2b_nobubble", {123'd0, out_valid, rk_idx}, {123'd0, 1'b0, 4'd1});
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("b2b_lat2", 128'(n + 1), 128'd11);
        check("b2b_ct2", out_data, CT_C);
        tick();

        // Reset at round 5 discards the block
        keysel   = 1'b0;
        in_data  = PT_B;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (rk_idx != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        check("abort_r5", 128'(rk_idx), 128'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_flags", {125'd0, out_valid, busy, in_ready}, {125'd0, 3'b001});
        check("abort_data", out_data, '0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_noout", 128'(seen), 128'd0);
        run_block("post_abort", PT_B, CT_B, 1'b0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
